// File: rtl/sdma_rdata_collect_pkg.sv
// Shared SDMA read-data constants: data widths, source port id encodings
// (also used by the write-data demux) and the fixed return-port ordering.
package sdma_rdata_collect_pkg;

  localparam int SDMA_CACHEDATAWIDTH      = 128;
  localparam int SDMA_AHBDATAWIDTH        = 32;
  localparam int SDMA_INST_SRCPORTIDWIDTH = 3;

  localparam logic [2:0] SDMA_PORTID_AHB = 3'b000;
  localparam logic [2:0] SDMA_PORTID_DC1 = 3'b100;
  localparam logic [2:0] SDMA_PORTID_DC2 = 3'b101;
  localparam logic [2:0] SDMA_PORTID_WC1 = 3'b110;
  localparam logic [2:0] SDMA_PORTID_WC2 = 3'b111;

  // Return ports in a fixed index order; the index is used for the
  // per-port valid/data vectors inside the collector.
  typedef enum logic [2:0] {
    RP_AHB = 3'd0,
    RP_DC1 = 3'd1,
    RP_DC2 = 3'd2,
    RP_WC1 = 3'd3,
    RP_WC2 = 3'd4
  } rport_e;

  localparam int SDMA_NUM_RPORTS = 5;

  // Port id for each return-port index (element 0 = AHB).
  localparam logic [SDMA_NUM_RPORTS-1:0][2:0] SDMA_PORTID_LIST = {
    SDMA_PORTID_WC2, SDMA_PORTID_WC1, SDMA_PORTID_DC2,
    SDMA_PORTID_DC1, SDMA_PORTID_AHB
  };

endpackage

// File: rtl/sdma_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sdma_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head entry is visible without a read request (fall-through).
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sdma_rdata_collect.sv
// SDMA read-data collector: tracks read requests in order by source port,
// gathers returns from AHB and the four cache ports, and hands them to the
// core in request order. Credits cover tags plus buffered data, so returns
// from non-stallable caches always find room in the output buffer.
module sdma_rdata_collect
  import sdma_rdata_collect_pkg::*;
#(
  parameter int CACHE_DW = SDMA_CACHEDATAWIDTH,
  parameter int AHB_DW   = SDMA_AHBDATAWIDTH,
  parameter int PORTID_W = SDMA_INST_SRCPORTIDWIDTH,
  parameter int OUTSTD   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rd_req,
  input  logic [PORTID_W-1:0] i_inst_srcportid,
  output logic                o_rd_gnt,
  input  logic                i_sdma_ahbrvalid,
  input  logic [AHB_DW-1:0]   i_sdma_ahbrdata,
  input  logic                i_sdma_dc1rvalid,
  input  logic                i_sdma_dc2rvalid,
  input  logic                i_sdma_wc1rvalid,
  input  logic                i_sdma_wc2rvalid,
  input  logic [CACHE_DW-1:0] i_sdma_dc1rdata,
  input  logic [CACHE_DW-1:0] i_sdma_dc2rdata,
  input  logic [CACHE_DW-1:0] i_sdma_wc1rdata,
  input  logic [CACHE_DW-1:0] i_sdma_wc2rdata,
  output logic                o_sdma_sportrvalid,
  output logic [CACHE_DW-1:0] o_sdma_sportrdata,
  output logic                o_sdma_sportrerr,
  input  logic                i_sdma_sportrready,
  output logic                o_order_err,
  output logic                o_busy
);

  localparam int AW = $clog2(OUTSTD);
  localparam int NP = SDMA_NUM_RPORTS;

  // Tag FIFO: {port id, invalid flag}
  logic                  tag_push;
  logic [PORTID_W:0]     tag_push_data;
  logic                  tag_pop;
  logic [PORTID_W:0]     tag_head;
  logic                  tag_empty;
  logic [AW:0]           tag_count;
  logic [PORTID_W-1:0]   head_port;
  logic                  head_inv;
  logic                  head_valid;

  // Output buffer: {data, err flag}
  logic                  out_push;
  logic [CACHE_DW:0]     out_push_data;
  logic                  out_pop;
  logic [CACHE_DW:0]     out_head;
  logic                  out_empty;
  logic [AW:0]           out_count;

  logic [AW+1:0]         used;
  logic [NP-1:0]         rvalid_vec;
  logic [NP-1:0][CACHE_DW-1:0] rdata_vec;
  logic [NP-1:0]         req_match;
  logic [NP-1:0]         head_match;
  logic [NP-1:0]         stray_vec;
  logic                  sel_rvalid;
  logic [CACHE_DW-1:0]   sel_rdata;
  logic                  order_err_reg;

  // Return ports gathered into index-ordered vectors.
  assign rvalid_vec = {i_sdma_wc2rvalid, i_sdma_wc1rvalid, i_sdma_dc2rvalid,
                       i_sdma_dc1rvalid, i_sdma_ahbrvalid};
  assign rdata_vec  = {i_sdma_wc2rdata, i_sdma_wc1rdata, i_sdma_dc2rdata,
                       i_sdma_dc1rdata, CACHE_DW'(i_sdma_ahbrdata)};

  // Credits: tags plus buffered entries; a head resolution only moves an
  // entry between the two FIFOs so it never changes this sum.
  assign used     = (AW+2)'(tag_count) + (AW+2)'(out_count);
  assign o_rd_gnt = (used < (AW+2)'(OUTSTD));
  assign o_busy   = (used != '0);

  assign head_valid = !tag_empty;
  assign head_port  = tag_head[PORTID_W:1];
  assign head_inv   = tag_head[0];

  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    assign req_match[gi]  = (i_inst_srcportid == PORTID_W'(SDMA_PORTID_LIST[gi]));
    assign head_match[gi] = head_valid && !head_inv &&
                            (head_port == PORTID_W'(SDMA_PORTID_LIST[gi]));
    // Anything returning on a port that is not the head's is dropped.
    assign stray_vec[gi]  = rvalid_vec[gi] && !head_match[gi];
  end

  assign tag_push      = i_rd_req && o_rd_gnt;
  assign tag_push_data = {i_inst_srcportid, ~(|req_match)};

  assign sel_rvalid = |(rvalid_vec & head_match);

  // One-hot select of the head port's return data.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NP; i++) begin
      if (head_match[i]) sel_rdata = rdata_vec[i];
    end
  end

  // Head resolves either on its port's return or at once if it is invalid.
  assign tag_pop       = head_valid && (head_inv || sel_rvalid);
  assign out_push      = tag_pop;
  assign out_push_data = head_inv ? {{CACHE_DW{1'b0}}, 1'b1} : {sel_rdata, 1'b0};

  assign o_sdma_sportrvalid = !out_empty;
  assign out_pop            = o_sdma_sportrvalid && i_sdma_sportrready;
  // Gate with valid so the buffer's unwritten storage never leaks out.
  assign o_sdma_sportrdata  = o_sdma_sportrvalid ? out_head[CACHE_DW:1] : '0;
  assign o_sdma_sportrerr   = o_sdma_sportrvalid && out_head[0];
  assign o_order_err        = order_err_reg;

  // Registered single pulse for any stray returns in a cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) order_err_reg <= 1'b0;
    else          order_err_reg <= |stray_vec;
  end

  sdma_sync_fifo #(.WIDTH(PORTID_W + 1), .DEPTH(OUTSTD)) u_tag_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (tag_push),
    .push_data (tag_push_data),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  sdma_sync_fifo #(.WIDTH(CACHE_DW + 1), .DEPTH(OUTSTD)) u_out_buf (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (out_push),
    .push_data (out_push_data),
    .pop       (out_pop),
    .pop_data  (out_head),
    .empty     (out_empty),
    .count     (out_count)
  );

endmodule

// File: tb/tb_sdma_rdata_collect.sv
// Scoreboard bench for sdma_rdata_collect: expected {err, data} words are
// queued as stimulus is driven and popped as the core side accepts output.
module tb_sdma_rdata_collect;
  import sdma_rdata_collect_pkg::*;

  localparam int CDW = 128;
  localparam int ADW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rd_req = 1'b0;
  logic [2:0]     srcportid = '0;
  logic           rd_gnt;
  logic           ahbrvalid = 1'b0;
  logic [ADW-1:0] ahbrdata = '0;
  logic           dc1rvalid = 1'b0, dc2rvalid = 1'b0, wc1rvalid = 1'b0, wc2rvalid = 1'b0;
  logic [CDW-1:0] dc1rdata = '0, dc2rdata = '0, wc1rdata = '0, wc2rdata = '0;
  logic           sportrvalid;
  logic [CDW-1:0] sportrdata;
  logic           sportrerr;
  logic           sportrready = 1'b1;
  logic           order_err;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CDW:0] exp_q [$];

  always #5 clk = ~clk;

  sdma_rdata_collect dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_rd_req           (rd_req),
    .i_inst_srcportid   (srcportid),
    .o_rd_gnt           (rd_gnt),
    .i_sdma_ahbrvalid   (ahbrvalid),
    .i_sdma_ahbrdata    (ahbrdata),
    .i_sdma_dc1rvalid   (dc1rvalid),
    .i_sdma_dc2rvalid   (dc2rvalid),
    .i_sdma_wc1rvalid   (wc1rvalid),
    .i_sdma_wc2rvalid   (wc2rvalid),
    .i_sdma_dc1rdata    (dc1rdata),
    .i_sdma_dc2rdata    (dc2rdata),
    .i_sdma_wc1rdata    (wc1rdata),
    .i_sdma_wc2rdata    (wc2rdata),
    .o_sdma_sportrvalid (sportrvalid),
    .o_sdma_sportrdata  (sportrdata),
    .o_sdma_sportrerr   (sportrerr),
    .i_sdma_sportrready (sportrready),
    .o_order_err        (order_err),
    .o_busy             (busy)
  );

  task automatic chk_eq(input string tag, input logic [CDW:0] got, input logic [CDW:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core-side monitor: every accepted output is one transaction.
  always @(negedge clk) begin
    if (rst_n && sportrvalid && sportrready) begin
      chk_eq("sb_has_entry", (CDW+1)'(exp_q.size() != 0), (CDW+1)'(1));
      if (exp_q.size() != 0) begin
        logic [CDW:0] e;
        e = exp_q.pop_front();
        $display("out  err=%0b data=%h", sportrerr, sportrdata);
        chk_eq("out_word", {sportrerr, sportrdata}, e);
      end
    end
  end

  // One-cycle request; returns aligned just after a rising edge.
  task automatic do_req(input logic [2:0] id);
    rd_req = 1'b1;
    srcportid = id;
    $display("req  port=%b gnt=%0b", id, rd_gnt);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  // One-cycle return on a port; optionally queue the expected output.
  task automatic do_ret(input rport_e p, input logic [CDW-1:0] d, input bit expect_out);
    case (p)
      RP_AHB: begin ahbrvalid = 1'b1; ahbrdata = d[ADW-1:0]; end
      RP_DC1: begin dc1rvalid = 1'b1; dc1rdata = d; end
      RP_DC2: begin dc2rvalid = 1'b1; dc2rdata = d; end
      RP_WC1: begin wc1rvalid = 1'b1; wc1rdata = d; end
      default: begin wc2rvalid = 1'b1; wc2rdata = d; end
    endcase
    if (expect_out) begin
      if (p == RP_AHB) exp_q.push_back({1'b0, {(CDW-ADW){1'b0}}, d[ADW-1:0]});
      else             exp_q.push_back({1'b0, d});
    end
    $display("ret  port=%0d data=%h", int'(p), d);
    @(posedge clk); #1;
    ahbrvalid = 1'b0; dc1rvalid = 1'b0; dc2rvalid = 1'b0;
    wc1rvalid = 1'b0; wc2rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sportrvalid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk_eq("drain_done", (CDW+1)'(sportrvalid), '0);
  endtask

  initial begin
    logic [CDW-1:0] pat_a5;
    pat_a5 = {(CDW/8){8'hA5}};

    // Reset release
    idle(2);
    rst_n = 1'b1;
    #1;
    chk_eq("rst_valid", (CDW+1)'(sportrvalid), '0);
    chk_eq("rst_data",  {sportrerr, sportrdata}, '0);
    chk_eq("rst_oerr",  (CDW+1)'(order_err), '0);
    chk_eq("rst_busy",  (CDW+1)'(busy), '0);
    chk_eq("rst_gnt",   (CDW+1)'(rd_gnt), (CDW+1)'(1));

    // Single DC1 request, return one cycle later
    do_req(SDMA_PORTID_DC1);
    chk_eq("t1_busy_req", (CDW+1)'(busy), (CDW+1)'(1));
    do_ret(RP_DC1, pat_a5, 1'b1);
    chk_eq("t1_latency", (CDW+1)'(sportrvalid), (CDW+1)'(1));
    chk_eq("t1_oerr", (CDW+1)'(order_err), '0);
    idle(1);
    chk_eq("t1_busy_fall", (CDW+1)'(busy), '0);

    // AHB zero-extension
    do_req(SDMA_PORTID_AHB);
    do_ret(RP_AHB, CDW'(32'hDEADBEEF) | {32'h1234_5678, 96'h0}, 1'b1);
    idle(1);

    // Ordering: WC1 return while DC2 is at the head is dropped
    do_req(SDMA_PORTID_DC2);
    do_req(SDMA_PORTID_WC1);
    do_ret(RP_WC1, {4{32'h0BAD_0BAD}}, 1'b0);
    chk_eq("ord_pulse", (CDW+1)'(order_err), (CDW+1)'(1));
    chk_eq("ord_no_out", (CDW+1)'(sportrvalid), '0);
    idle(1);
    chk_eq("ord_pulse_end", (CDW+1)'(order_err), '0);
    do_ret(RP_DC2, {4{32'h2222_0002}}, 1'b1);
    do_ret(RP_WC1, {4{32'h3333_0003}}, 1'b1);
    idle(2);

    // Invalid port id; a simultaneous AHB return is stray, not consumed
    exp_q.push_back({1'b1, {CDW{1'b0}}});
    do_req(3'b010);
    do_ret(RP_AHB, CDW'(32'hCAFE_F00D), 1'b0);
    chk_eq("inv_out_valid", (CDW+1)'(sportrvalid), (CDW+1)'(1));
    chk_eq("inv_out_err", (CDW+1)'(sportrerr), (CDW+1)'(1));
    chk_eq("inv_stray", (CDW+1)'(order_err), (CDW+1)'(1));
    idle(2);
    chk_eq("inv_busy", (CDW+1)'(busy), '0);

    // Credit backpressure
    sportrready = 1'b0;
    do_req(SDMA_PORTID_DC1);
    do_req(SDMA_PORTID_DC2);
    do_req(SDMA_PORTID_WC1);
    do_req(SDMA_PORTID_WC2);
    chk_eq("bp_gnt_tags", (CDW+1)'(rd_gnt), '0);
    do_req(3'b011);  // not granted: must never produce an output
    do_ret(RP_DC1, {4{32'hD1D1_0001}}, 1'b1);
    do_ret(RP_DC2, {4{32'hD2D2_0002}}, 1'b1);
    do_ret(RP_WC1, {4{32'hE1E1_0003}}, 1'b1);
    do_ret(RP_WC2, {4{32'hE2E2_0004}}, 1'b1);
    chk_eq("bp_gnt_full", (CDW+1)'(rd_gnt), '0);
    chk_eq("bp_held", (CDW+1)'(sportrvalid), (CDW+1)'(1));
    sportrready = 1'b1;
    @(posedge clk); #1;
    sportrready = 1'b0;
    chk_eq("bp_gnt_back", (CDW+1)'(rd_gnt), (CDW+1)'(1));
    sportrready = 1'b1;
    drain(20);
    chk_eq("bp_busy", (CDW+1)'(busy), '0);

    // Reset mid-operation
    do_req(SDMA_PORTID_DC1);
    do_req(SDMA_PORTID_DC2);
    do_req(SDMA_PORTID_WC1);
    chk_eq("mr_busy_pre", (CDW+1)'(busy), (CDW+1)'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_eq("mr_busy", (CDW+1)'(busy), '0);
    chk_eq("mr_gnt", (CDW+1)'(rd_gnt), (CDW+1)'(1));
    do_ret(RP_DC1, {4{32'h1A7E_0001}}, 1'b0);
    chk_eq("mr_late_pulse", (CDW+1)'(order_err), (CDW+1)'(1));
    idle(3);
    chk_eq("mr_no_out", (CDW+1)'(sportrvalid), '0);

    chk_eq("sb_drained", (CDW+1)'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
